gemm_insn_encoder: RTL and testbench

- Builds 128-bit GEMM instructions for the gemm core from field-level commands.
- Commands arrive over a valid/ready interface from the host/scheduler side.
- Accepted commands are validated, packed per the GEMM instruction field map, and buffered in a small FIFO.
- Each instruction is presented to the core on `insn`, held stable until the core reports completion, then the next one is issued.

---
 rtl/gemm_pkg.sv | 97 +++++++++
 rtl/gemm_insn_encoder_if.sv | 35 +++
 rtl/insn_fifo.sv | 63 ++++++
 rtl/gemm_insn_encoder.sv | 142 ++++++++++++++
 tb/tb_gemm_insn_encoder.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gemm_pkg.sv
// Shared field map, error codes and FSM states for the GEMM
// instruction encoder and its testbench.
package gemm_pkg;

    localparam int INSN_W = 128;

    localparam int OPC_LSB      = 0;
    localparam int OPC_W        = 3;
    localparam int DEP_LSB      = 3;
    localparam int DEP_W        = 4;
    localparam int RST_BIT      = 7;
    localparam int UOP_BGN_LSB  = 8;
    localparam int UOP_BGN_W    = 13;
    localparam int UOP_END_LSB  = 21;
    localparam int UOP_END_W    = 14;
    localparam int ITER_OUT_LSB = 35;
    localparam int ITER_IN_LSB  = 49;
    localparam int ITER_W       = 14;
    localparam int DST_OUT_LSB  = 63;
    localparam int DST_IN_LSB   = 74;
    localparam int SRC_OUT_LSB  = 85;
    localparam int SRC_IN_LSB   = 96;
    localparam int IDX_W        = 11;
    localparam int WGT_OUT_LSB  = 107;
    localparam int WGT_IN_LSB   = 117;
    localparam int WGT_W        = 10;

    localparam int UOP_ACC_LSB = 0;
    localparam int UOP_ACC_W   = 11;
    localparam int UOP_INP_LSB = 11;
    localparam int UOP_INP_W   = 11;
    localparam int UOP_WGT_LSB = 22;
    localparam int UOP_WGT_W   = 10;

    localparam logic [2:0] OPCODE_GEMM = 3'd2;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_OPCODE    = 3'd1,
        ERR_UOP_RANGE = 3'd2,
        ERR_ITER_ZERO = 3'd3,
        ERR_TIMEOUT   = 3'd4
    } err_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_GAP
    } state_e;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  dep;
        logic        reset_reg;
        logic [12:0] uop_bgn;
        logic [13:0] uop_end;
        logic [13:0] iter_out;
        logic [13:0] iter_in;
        logic [10:0] dst_out;
        logic [10:0] dst_in;
        logic [10:0] src_out;
        logic [10:0] src_in;
        logic [9:0]  wgt_out;
        logic [9:0]  wgt_in;
    } gemm_cmd_t;

    function automatic logic [INSN_W-1:0] pack_insn(gemm_cmd_t c);
        logic [INSN_W-1:0] w;
        w = '0;
        w[OPC_LSB +: OPC_W]          = c.opcode;
        w[DEP_LSB +: DEP_W]          = c.dep;
        w[RST_BIT]                   = c.reset_reg;
        w[UOP_BGN_LSB +: UOP_BGN_W]  = c.uop_bgn;
        w[UOP_END_LSB +: UOP_END_W]  = c.uop_end;
        w[ITER_OUT_LSB +: ITER_W]    = c.iter_out;
        w[ITER_IN_LSB +: ITER_W]     = c.iter_in;
        w[DST_OUT_LSB +: IDX_W]      = c.dst_out;
        w[DST_IN_LSB +: IDX_W]       = c.dst_in;
        w[SRC_OUT_LSB +: IDX_W]      = c.src_out;
        w[SRC_IN_LSB +: IDX_W]       = c.src_in;
        w[WGT_OUT_LSB +: WGT_W]      = c.wgt_out;
        w[WGT_IN_LSB +: WGT_W]       = c.wgt_in;
        return w;
    endfunction

    function automatic err_e check_cmd(gemm_cmd_t c);
        if (c.opcode != OPCODE_GEMM)
            return ERR_OPCODE;
        else if (c.uop_end <= {1'b0, c.uop_bgn})
            return ERR_UOP_RANGE;
        else if (c.iter_out == '0 || c.iter_in == '0)
            return ERR_ITER_ZERO;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/gemm_insn_encoder_if.sv
// Field-level command channel from the host/scheduler into the
// encoder, with a valid/ready handshake.
interface gemm_insn_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [3:0]  cmd_dep;
    logic        cmd_reset_reg;
    logic [12:0] cmd_uop_bgn;
    logic [13:0] cmd_uop_end;
    logic [13:0] cmd_iter_out;
    logic [13:0] cmd_iter_in;
    logic [10:0] cmd_dst_out;
    logic [10:0] cmd_dst_in;
    logic [10:0] cmd_src_out;
    logic [10:0] cmd_src_in;
    logic [9:0]  cmd_wgt_out;
    logic [9:0]  cmd_wgt_in;

    modport master (
        output cmd_valid, cmd_opcode, cmd_dep, cmd_reset_reg,
        output cmd_uop_bgn, cmd_uop_end, cmd_iter_out, cmd_iter_in,
        output cmd_dst_out, cmd_dst_in, cmd_src_out, cmd_src_in,
        output cmd_wgt_out, cmd_wgt_in,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_dep, cmd_reset_reg,
        input  cmd_uop_bgn, cmd_uop_end, cmd_iter_out, cmd_iter_in,
        input  cmd_dst_out, cmd_dst_in, cmd_src_out, cmd_src_in,
        input  cmd_wgt_out, cmd_wgt_in,
        output cmd_ready
    );
endinterface

// File: rtl/insn_fifo.sv
// Synchronous FIFO of packed instruction words; full/empty are
// decoded from the registered occupancy only.
module insn_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = count_q == FULL_CNT;
    assign empty   = count_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/gemm_insn_encoder.sv
// Validates and packs GEMM commands, buffers them, and issues one
// instruction at a time to the gemm core with a watchdog.
module gemm_insn_encoder
    import gemm_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    gemm_insn_encoder_if.slave   cmd,
    output logic [INSN_W-1:0]    insn,
    output logic                 insn_valid,
    input  logic                 insn_done,
    output logic                 err,
    output logic [2:0]           err_code,
    output logic [CNT_WIDTH-1:0] issued_cnt,
    output logic                 busy
);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    gemm_cmd_t         c;
    err_e              chk;
    logic [INSN_W-1:0] fifo_rdata;
    logic              full, empty, accept, push, pop;

    state_e               state_q, state_d;
    logic [INSN_W-1:0]    insn_q, insn_d;
    logic                 insn_valid_q, insn_valid_d;
    logic                 err_q, err_d;
    logic [2:0]           err_code_q, err_code_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          wdog_q, wdog_d;

    assign c = '{
        opcode:   cmd.cmd_opcode,
        dep:      cmd.cmd_dep,
        reset_reg: cmd.cmd_reset_reg,
        uop_bgn:  cmd.cmd_uop_bgn,
        uop_end:  cmd.cmd_uop_end,
        iter_out: cmd.cmd_iter_out,
        iter_in:  cmd.cmd_iter_in,
        dst_out:  cmd.cmd_dst_out,
        dst_in:   cmd.cmd_dst_in,
        src_out:  cmd.cmd_src_out,
        src_in:   cmd.cmd_src_in,
        wgt_out:  cmd.cmd_wgt_out,
        wgt_in:   cmd.cmd_wgt_in
    };

    assign chk           = check_cmd(c);
    assign cmd.cmd_ready = !full;
    assign accept        = cmd.cmd_valid && !full;
    assign push          = accept && (chk == ERR_NONE);

    insn_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSN_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .wdata (pack_insn(c)),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d      = state_q;
        insn_d       = insn_q;
        insn_valid_d = insn_valid_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        cnt_d        = cnt_q;
        wdog_d       = wdog_q;
        pop          = 1'b0;
        if (accept && chk != ERR_NONE) begin
            err_d      = 1'b1;
            err_code_d = chk;
        end
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    insn_d       = fifo_rdata;
                    insn_valid_d = 1'b1;
                    wdog_d       = '0;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                // Completion outranks a watchdog expiry in the same cycle.
                if (insn_done) begin
                    cnt_d        = cnt_q + 1'b1;
                    insn_d       = '0;
                    insn_valid_d = 1'b0;
                    state_d      = S_GAP;
                end else if (TIMEOUT != 0 && wdog_q == WD_LAST) begin
                    err_d        = 1'b1;
                    err_code_d   = ERR_TIMEOUT;
                    insn_d       = '0;
                    insn_valid_d = 1'b0;
                    state_d      = S_GAP;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            insn_q       <= '0;
            insn_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
            cnt_q        <= '0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            insn_q       <= insn_d;
            insn_valid_q <= insn_valid_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            cnt_q        <= cnt_d;
            wdog_q       <= wdog_d;
        end
    end

    assign insn       = insn_q;
    assign insn_valid = insn_valid_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign issued_cnt = cnt_q;
    assign busy       = (state_q != S_IDLE) || !empty;
endmodule

// File: tb/tb_gemm_insn_encoder.sv
// Directed bench: dut_a uses the default watchdog/counter, dut_b a
// short watchdog and a 2-bit counter.
module tb_gemm_insn_encoder;
    import gemm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gemm_insn_encoder_if ifa ();
    gemm_insn_encoder_if ifb ();

    logic [127:0] insn_a, insn_b;
    logic         insn_valid_a, insn_valid_b;
    logic         done_a, done_b;
    logic         err_a, err_b;
    logic [2:0]   code_a, code_b;
    logic [15:0]  cnt_a;
    logic [1:0]   cnt_b;
    logic         busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    gemm_insn_encoder #(
        .FIFO_DEPTH (2),
        .TIMEOUT    (4096),
        .CNT_WIDTH  (16)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .cmd        (ifa),
        .insn       (insn_a),
        .insn_valid (insn_valid_a),
        .insn_done  (done_a),
        .err        (err_a),
        .err_code   (code_a),
        .issued_cnt (cnt_a),
        .busy       (busy_a)
    );

    gemm_insn_encoder #(
        .FIFO_DEPTH (2),
        .TIMEOUT    (8),
        .CNT_WIDTH  (2)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .cmd        (ifb),
        .insn       (insn_b),
        .insn_valid (insn_valid_b),
        .insn_done  (done_b),
        .err        (err_b),
        .err_code   (code_b),
        .issued_cnt (cnt_b),
        .busy       (busy_b)
    );

    // Expected word built from the field map by hand; fixed side fields.
    function automatic logic [127:0] exp_word(
        logic [12:0] ub, logic [13:0] ue, logic [13:0] io,
        logic [13:0] ii, logic [10:0] tag);
        return {1'b0, 10'd4, 10'd4, 11'd4, 11'd4, 11'd1, tag,
                ii, io, ue, ub, tag[4], tag[3:0], 3'd2};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic set_fields(
        input logic [2:0] op, input logic [12:0] ub, input logic [13:0] ue,
        input logic [13:0] io, input logic [13:0] ii, input logic [10:0] tag);
        ifa.cmd_opcode = op;      ifb.cmd_opcode = op;
        ifa.cmd_dep = tag[3:0];   ifb.cmd_dep = tag[3:0];
        ifa.cmd_reset_reg = tag[4]; ifb.cmd_reset_reg = tag[4];
        ifa.cmd_uop_bgn = ub;     ifb.cmd_uop_bgn = ub;
        ifa.cmd_uop_end = ue;     ifb.cmd_uop_end = ue;
        ifa.cmd_iter_out = io;    ifb.cmd_iter_out = io;
        ifa.cmd_iter_in = ii;     ifb.cmd_iter_in = ii;
        ifa.cmd_dst_out = tag;    ifb.cmd_dst_out = tag;
        ifa.cmd_dst_in = 11'd1;   ifb.cmd_dst_in = 11'd1;
        ifa.cmd_src_out = 11'd4;  ifb.cmd_src_out = 11'd4;
        ifa.cmd_src_in = 11'd4;   ifb.cmd_src_in = 11'd4;
        ifa.cmd_wgt_out = 10'd4;  ifb.cmd_wgt_out = 10'd4;
        ifa.cmd_wgt_in = 10'd4;   ifb.cmd_wgt_in = 10'd4;
    endtask

    // Returns 1ns after the accepting edge.
    task automatic send(
        input bit b, input logic [2:0] op, input logic [12:0] ub,
        input logic [13:0] ue, input logic [13:0] io,
        input logic [13:0] ii, input logic [10:0] tag);
        int   n;
        logic rdy;
        set_fields(op, ub, ue, io, ii, tag);
        if (b) ifb.cmd_valid = 1'b1;
        else   ifa.cmd_valid = 1'b1;
        n   = 0;
        rdy = b ? ifb.cmd_ready : ifa.cmd_ready;
        while (!rdy && n < 20) begin
            tick();
            n++;
            rdy = b ? ifb.cmd_ready : ifa.cmd_ready;
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL send_ready got %b want 1 (tag %0d)", rdy, tag);
        end
        tick();
        ifa.cmd_valid = 1'b0;
        ifb.cmd_valid = 1'b0;
    endtask

    task automatic pulse_done(input bit b);
        if (b) done_b = 1'b1;
        else   done_a = 1'b1;
        tick();
        done_a = 1'b0;
        done_b = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({insn_a, insn_valid_a} !== 129'd0) begin
            errors++;
            $display("FAIL reset_insn got %h/%b want 0/0", insn_a, insn_valid_a);
        end
        checks++;
        if ({err_a, code_a, busy_a} !== 5'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 00000", {err_a, code_a, busy_a});
        end
        checks++;
        if ({cnt_a, cnt_b} !== 18'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt_a, cnt_b);
        end
        checks++;
        if (ifa.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", ifa.cmd_ready);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single;
        logic [127:0] w;
        logic         held;
        do_reset();
        w = exp_word(13'd1, 14'd10, 14'd4, 14'd4, 11'd1);
        send(0, 3'd2, 13'd1, 14'd10, 14'd4, 14'd4, 11'd1);
        checks++;
        if (insn_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL single_early got %b want 0", insn_valid_a);
        end
        tick();
        checks++;
        if (insn_a !== w || insn_valid_a !== 1'b1) begin
            errors++;
            $display("FAIL single_insn got %h/%b want %h/1", insn_a, insn_valid_a, w);
        end
        checks++;
        if ({insn_a[2:0], insn_a[20:8], insn_a[34:21], insn_a[48:35],
             insn_a[62:49], insn_a[73:63], insn_a[95:85], insn_a[116:107],
             insn_a[127]} !==
            {3'd2, 13'd1, 14'd10, 14'd4, 14'd4, 11'd1, 11'd4, 10'd4, 1'b0}) begin
            errors++;
            $display("FAIL single_fields got %h want fields 2/1/10/4/4/1/4/4/0", insn_a);
        end
        held = 1'b1;
        for (int i = 0; i < 49; i++) begin
            tick();
            if (insn_a !== w) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL single_hold got unstable want %h", w);
        end
        pulse_done(0);
        checks++;
        if ({insn_a, insn_valid_a} !== 129'd0 || cnt_a !== 16'd1) begin
            errors++;
            $display("FAIL single_done got %h/%b cnt %0d want 0/0 cnt 1",
                     insn_a, insn_valid_a, cnt_a);
        end
        tick();
        checks++;
        if (insn_a !== 128'd0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got %h busy %b want 0 busy 0", insn_a, busy_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] w1, w2, w3;
        do_reset();
        w1 = exp_word(13'd1, 14'd10, 14'd4, 14'd4, 11'd11);
        w2 = exp_word(13'd2, 14'd20, 14'd3, 14'd5, 11'd12);
        w3 = exp_word(13'd3, 14'd30, 14'd2, 14'd6, 11'd13);
        send(0, 3'd2, 13'd1, 14'd10, 14'd4, 14'd4, 11'd11);
        send(0, 3'd2, 13'd2, 14'd20, 14'd3, 14'd5, 11'd12);
        send(0, 3'd2, 13'd3, 14'd30, 14'd2, 14'd6, 11'd13);
        checks++;
        if (ifa.cmd_ready !== 1'b0 || insn_a !== w1) begin
            errors++;
            $display("FAIL bp_full got ready %b insn %h want 0 %h",
                     ifa.cmd_ready, insn_a, w1);
        end
        set_fields(3'd2, 13'd4, 14'd40, 14'd1, 14'd1, 11'd99);
        ifa.cmd_valid = 1'b1;
        tick();
        tick();
        tick();
        ifa.cmd_valid = 1'b0;
        pulse_done(0);
        checks++;
        if (insn_a !== 128'd0) begin
            errors++;
            $display("FAIL bp_gap1 got %h want 0", insn_a);
        end
        tick();
        checks++;
        if (insn_a !== 128'd0 || ifa.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle1 got %h ready %b want 0 ready 0",
                     insn_a, ifa.cmd_ready);
        end
        tick();
        checks++;
        if (insn_a !== w2 || ifa.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got %h ready %b want %h ready 1",
                     insn_a, ifa.cmd_ready, w2);
        end
        pulse_done(0);
        tick();
        checks++;
        if (insn_a !== 128'd0) begin
            errors++;
            $display("FAIL bp_idle2 got %h want 0", insn_a);
        end
        tick();
        checks++;
        if (insn_a !== w3) begin
            errors++;
            $display("FAIL bp_third got %h want %h", insn_a, w3);
        end
        pulse_done(0);
        tick();
        tick();
        tick();
        checks++;
        if (cnt_a !== 16'd3 || insn_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL bp_end got cnt %0d valid %b busy %b want 3 0 0",
                     cnt_a, insn_valid_a, busy_a);
        end
    endtask

    task automatic test_validation;
        logic [127:0] w;
        do_reset();
        send(0, 3'd3, 13'd1, 14'd10, 14'd4, 14'd4, 11'd2);
        checks++;
        if ({err_a, code_a} !== 4'b1_001) begin
            errors++;
            $display("FAIL val_opcode got %b/%0d want 1/1", err_a, code_a);
        end
        tick();
        checks++;
        if ({err_a, code_a} !== 4'b0_001) begin
            errors++;
            $display("FAIL val_hold got %b/%0d want 0/1", err_a, code_a);
        end
        send(0, 3'd2, 13'd10, 14'd10, 14'd4, 14'd4, 11'd2);
        checks++;
        if ({err_a, code_a} !== 4'b1_010) begin
            errors++;
            $display("FAIL val_uop_eq got %b/%0d want 1/2", err_a, code_a);
        end
        send(0, 3'd2, 13'd1, 14'd10, 14'd4, 14'd0, 11'd2);
        checks++;
        if ({err_a, code_a} !== 4'b1_011) begin
            errors++;
            $display("FAIL val_iter got %b/%0d want 1/3", err_a, code_a);
        end
        send(0, 3'd5, 13'd10, 14'd10, 14'd0, 14'd0, 11'd2);
        checks++;
        if ({err_a, code_a} !== 4'b1_001) begin
            errors++;
            $display("FAIL val_prio1 got %b/%0d want 1/1", err_a, code_a);
        end
        send(0, 3'd2, 13'd10, 14'd9, 14'd0, 14'd4, 11'd2);
        checks++;
        if ({err_a, code_a} !== 4'b1_010) begin
            errors++;
            $display("FAIL val_prio2 got %b/%0d want 1/2", err_a, code_a);
        end
        tick();
        tick();
        checks++;
        if (insn_valid_a !== 1'b0 || busy_a !== 1'b0 || ifa.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL val_dropped got valid %b busy %b ready %b want 0 0 1",
                     insn_valid_a, busy_a, ifa.cmd_ready);
        end
        w = exp_word(13'h1FFF, 14'h2000, 14'd1, 14'd1, 11'd3);
        send(0, 3'd2, 13'h1FFF, 14'h2000, 14'd1, 14'd1, 11'd3);
        checks++;
        if ({err_a, code_a} !== 4'b0_010) begin
            errors++;
            $display("FAIL val_edge_err got %b/%0d want 0/2", err_a, code_a);
        end
        tick();
        checks++;
        if (insn_a !== w) begin
            errors++;
            $display("FAIL val_edge_insn got %h want %h", insn_a, w);
        end
        pulse_done(0);
        tick();
    endtask

    task automatic test_timeout;
        logic [127:0] w;
        logic         quiet;
        do_reset();
        w = exp_word(13'd1, 14'd10, 14'd4, 14'd4, 11'd6);
        send(1, 3'd2, 13'd1, 14'd10, 14'd4, 14'd4, 11'd6);
        tick();
        checks++;
        if (insn_b !== w || insn_valid_b !== 1'b1) begin
            errors++;
            $display("FAIL to_issue got %h/%b want %h/1", insn_b, insn_valid_b, w);
        end
        quiet = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (err_b !== 1'b0 || insn_valid_b !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL to_early got err/abort before 8 cycles want none");
        end
        tick();
        checks++;
        if ({err_b, code_b} !== 4'b1_100 || insn_b !== 128'd0 ||
            insn_valid_b !== 1'b0 || cnt_b !== 2'd0) begin
            errors++;
            $display("FAIL to_fire got err %b code %0d insn %h valid %b cnt %0d want 1 4 0 0 0",
                     err_b, code_b, insn_b, insn_valid_b, cnt_b);
        end
        tick();
        tick();
        send(1, 3'd2, 13'd1, 14'd10, 14'd4, 14'd4, 11'd7);
        tick();
        for (int i = 0; i < 7; i++) tick();
        pulse_done(1);
        checks++;
        if (err_b !== 1'b0 || cnt_b !== 2'd1 || insn_b !== 128'd0) begin
            errors++;
            $display("FAIL to_done_wins got err %b cnt %0d insn %h want 0 1 0",
                     err_b, cnt_b, insn_b);
        end
        tick();
        checks++;
        if (err_b !== 1'b0) begin
            errors++;
            $display("FAIL to_late got err %b want 0", err_b);
        end
    endtask

    task automatic test_reset_mid_busy;
        do_reset();
        send(0, 3'd2, 13'd1, 14'd10, 14'd4, 14'd4, 11'd20);
        tick();
        pulse_done(0);
        send(0, 3'd2, 13'd1, 14'd10, 14'd4, 14'd4, 11'd21);
        send(0, 3'd2, 13'd1, 14'd10, 14'd4, 14'd4, 11'd22);
        tick();
        checks++;
        if (insn_valid_a !== 1'b1 || cnt_a !== 16'd1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got valid %b cnt %0d busy %b want 1 1 1",
                     insn_valid_a, cnt_a, busy_a);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({insn_a, insn_valid_a} !== 129'd0 || cnt_a !== 16'd0 ||
            busy_a !== 1'b0 || ifa.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async got insn %h valid %b cnt %0d busy %b ready %b want 0 0 0 0 1",
                     insn_a, insn_valid_a, cnt_a, busy_a, ifa.cmd_ready);
        end
        tick();
        rst = 1'b1;
        pulse_done(0);
        tick();
        tick();
        checks++;
        if (cnt_a !== 16'd0 || insn_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_done_ignored got cnt %0d valid %b busy %b want 0 0 0",
                     cnt_a, insn_valid_a, busy_a);
        end
    endtask

    task automatic test_wrap;
        logic issued;
        do_reset();
        issued = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1, 3'd2, 13'd1, 14'd10, 14'd1, 14'd1, 11'(i + 8));
            tick();
            if (insn_valid_b !== 1'b1) issued = 1'b0;
            pulse_done(1);
            tick();
            if (i == 3) begin
                checks++;
                if (cnt_b !== 2'd0) begin
                    errors++;
                    $display("FAIL wrap_four got %0d want 0", cnt_b);
                end
            end
        end
        checks++;
        if (cnt_b !== 2'd1 || issued !== 1'b1) begin
            errors++;
            $display("FAIL wrap_five got cnt %0d issued %b want 1 1", cnt_b, issued);
        end
    endtask

    initial begin
        ifa.cmd_valid = 1'b0;
        ifb.cmd_valid = 1'b0;
        done_a = 1'b0;
        done_b = 1'b0;
        set_fields(3'd0, 13'd0, 14'd0, 14'd0, 14'd0, 11'd0);
        test_reset();
        test_single();
        test_back_to_back();
        test_validation();
        test_timeout();
        test_reset_mid_busy();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got stall want completion");
        $fatal(1, "bench stalled");
    end
endmodule
